// File: rtl/rr_stage.sv
// Register-read stage: 32x32 register file with write-back bypass, immediate extension, load-use detection.
// Latency: 1 cycle from ID/RR to RR/EX. Operand read, immediate extension and stall are combinational.
// Backpressure: stall is raised for one cycle on a load-use hazard unless flushed; a bubble is registered into RR/EX meanwhile.
module rr_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [5:0]        opcode,
    input  logic [5:0]        func,
    input  logic [25:0]       address,
    input  logic [15:0]       immediate,
    input  logic              RegDst,
    input  logic              ALUSrc,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Jump,
    input  logic [1:0]        ALUOp,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [31:0]       imm_o,
    output logic [4:0]        dest_o,
    output logic [4:0]        rs_o,
    output logic [4:0]        rt_o,
    output logic [5:0]        opcode_o,
    output logic [5:0]        func_o,
    output logic [25:0]       address_o,
    output logic              RegDst_o,
    output logic              ALUSrc_o,
    output logic              MemtoReg_o,
    output logic              RegWrite_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              Jump_o,
    output logic [1:0]        ALUOp_o
);

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;

    logic [DATA_W-1:0] regs [32];
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [31:0]       imm_ext;
    logic [4:0]        dest;
    logic              load_use;
    logic              bubble;

    // Register file: write-back port; r0 is never written so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Operand read with write-first bypass, immediate extension, destination select and hazard detect.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != 5'd0) begin
            rs_val = (wb_we && wb_addr == rs) ? wb_data : regs[rs];
        end
        if (rt != 5'd0) begin
            rt_val = (wb_we && wb_addr == rt) ? wb_data : regs[rt];
        end

        if (opcode == OP_ANDI || opcode == OP_ORI) begin
            imm_ext = {16'h0000, immediate};
        end else begin
            imm_ext = {{16{immediate[15]}}, immediate};
        end

        dest = RegDst ? rd : rt;

        // rt only counts as a source when the ALU takes it instead of the immediate.
        load_use = MemRead_o && dest_o != 5'd0 &&
                   (dest_o == rs || (dest_o == rt && !ALUSrc));
        stall    = load_use && !flush;
        bubble   = flush || load_use;
    end

    // RR/EX pipeline register: reset and bubbles (flush or load-use) clear every field.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            rs_data_o  <= '0;
            rt_data_o  <= '0;
            imm_o      <= '0;
            dest_o     <= '0;
            rs_o       <= '0;
            rt_o       <= '0;
            opcode_o   <= '0;
            func_o     <= '0;
            address_o  <= '0;
            RegDst_o   <= 1'b0;
            ALUSrc_o   <= 1'b0;
            MemtoReg_o <= 1'b0;
            RegWrite_o <= 1'b0;
            MemRead_o  <= 1'b0;
            MemWrite_o <= 1'b0;
            Jump_o     <= 1'b0;
            ALUOp_o    <= '0;
        end else begin
            rs_data_o  <= rs_val;
            rt_data_o  <= rt_val;
            imm_o      <= imm_ext;
            dest_o     <= dest;
            rs_o       <= rs;
            rt_o       <= rt;
            opcode_o   <= opcode;
            func_o     <= func;
            address_o  <= address;
            RegDst_o   <= RegDst;
            ALUSrc_o   <= ALUSrc;
            MemtoReg_o <= MemtoReg;
            RegWrite_o <= RegWrite;
            MemRead_o  <= MemRead;
            MemWrite_o <= MemWrite;
            Jump_o     <= Jump;
            ALUOp_o    <= ALUOp;
        end
    end

endmodule

// File: tb/tb_rr_stage.sv
// Bench for rr_stage: directed scenarios followed by random traffic against a reference model.
// Outputs are sampled 1 time unit after the rising edge; stall is sampled mid-cycle.
// Inputs change on the falling edge; stalled instructions are re-presented as ID/RR would.
module tb_rr_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  opcode, func;
    logic [25:0] address;
    logic [15:0] immediate;
    logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Jump;
    logic [1:0]  ALUOp;
    logic        flush, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic [31:0] rs_data_o, rt_data_o, imm_o;
    logic [4:0]  dest_o, rs_o, rt_o;
    logic [5:0]  opcode_o, func_o;
    logic [25:0] address_o;
    logic        RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o, MemRead_o, MemWrite_o, Jump_o;
    logic [1:0]  ALUOp_o;

    rr_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .opcode(opcode), .func(func),
        .address(address), .immediate(immediate), .RegDst(RegDst), .ALUSrc(ALUSrc),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .Jump(Jump), .ALUOp(ALUOp), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .stall(stall), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
        .imm_o(imm_o), .dest_o(dest_o), .rs_o(rs_o), .rt_o(rt_o), .opcode_o(opcode_o),
        .func_o(func_o), .address_o(address_o), .RegDst_o(RegDst_o), .ALUSrc_o(ALUSrc_o),
        .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .Jump_o(Jump_o), .ALUOp_o(ALUOp_o)
    );

    always #5 clk = ~clk;

    // Expected contents of the RR/EX register.
    typedef struct packed {
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  dest, rs, rt;
        logic [5:0]  op, fn;
        logic [25:0] addr;
        logic        regdst, alusrc, memtoreg, regwrite, memread, memwrite, jump;
        logic [1:0]  aluop;
    } ex_t;

    ex_t         exp_q = '0;
    logic [31:0] ref_rf [32];
    logic        exp_stall;
    logic        last_stall = 1'b0;
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (wb_we && wb_addr == r) return wb_data;
        return ref_rf[r];
    endfunction

    // Hazard: the load now in EX writes a register this instruction reads.
    function automatic logic ref_stall();
        logic hz;
        hz = exp_q.memread && exp_q.dest != 5'd0 &&
             (exp_q.dest == rs || (exp_q.dest == rt && !ALUSrc));
        return hz && !flush;
    endfunction

    // What the next rising edge should leave in RR/EX and in the register file.
    task automatic model_edge();
        ex_t nx;
        logic hz;
        hz = exp_q.memread && exp_q.dest != 5'd0 &&
             (exp_q.dest == rs || (exp_q.dest == rt && !ALUSrc));
        nx = '0;
        if (!rst && !flush && !hz) begin
            nx.rsd = ref_read(rs);
            nx.rtd = ref_read(rt);
            nx.imm = (opcode == 6'h0C || opcode == 6'h0D) ? {16'h0, immediate}
                                                          : {{16{immediate[15]}}, immediate};
            nx.dest = RegDst ? rd : rt;
            nx.rs = rs;  nx.rt = rt;  nx.op = opcode;  nx.fn = func;  nx.addr = address;
            nx.regdst = RegDst;  nx.alusrc = ALUSrc;  nx.memtoreg = MemtoReg;
            nx.regwrite = RegWrite;  nx.memread = MemRead;  nx.memwrite = MemWrite;
            nx.jump = Jump;  nx.aluop = ALUOp;
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
        end else if (wb_we && wb_addr != 5'd0) begin
            ref_rf[wb_addr] = wb_data;
        end
        exp_q = nx;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rs_data"},  rs_data_o,  exp_q.rsd);
        check({tag, ".rt_data"},  rt_data_o,  exp_q.rtd);
        check({tag, ".imm"},      imm_o,      exp_q.imm);
        check({tag, ".dest"},     {27'h0, dest_o}, {27'h0, exp_q.dest});
        check({tag, ".rs_o"},     {27'h0, rs_o},   {27'h0, exp_q.rs});
        check({tag, ".rt_o"},     {27'h0, rt_o},   {27'h0, exp_q.rt});
        check({tag, ".op"},       {26'h0, opcode_o}, {26'h0, exp_q.op});
        check({tag, ".fn"},       {26'h0, func_o},   {26'h0, exp_q.fn});
        check({tag, ".addr"},     {6'h0, address_o}, {6'h0, exp_q.addr});
        check({tag, ".ctl"},
              {22'h0, RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o, MemRead_o, MemWrite_o, Jump_o, ALUOp_o},
              {22'h0, exp_q.regdst, exp_q.alusrc, exp_q.memtoreg, exp_q.regwrite,
               exp_q.memread, exp_q.memwrite, exp_q.jump, exp_q.aluop});
    endtask

    // One clock cycle with the inputs currently driven (called just after a falling edge).
    task automatic cycle(input string tag, input bit chk_stall);
        #1;
        exp_stall = ref_stall();
        if (chk_stall) check({tag, ".stall"}, {31'h0, stall}, {31'h0, exp_stall});
        last_stall = exp_stall && !rst;
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rs = 0; rt = 0; rd = 0; opcode = 0; func = 0; address = 0; immediate = 0;
        RegDst = 0; ALUSrc = 0; MemtoReg = 0; RegWrite = 0; MemRead = 0; MemWrite = 0;
        Jump = 0; ALUOp = 0; flush = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic drive_lw(input logic [4:0] dst);
        idle_inputs();
        opcode = 6'h23; rs = 5'd2; rt = dst; immediate = 16'h0010;
        ALUSrc = 1; MemtoReg = 1; RegWrite = 1; MemRead = 1;
    endtask

    task automatic drive_add(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        idle_inputs();
        rs = s; rt = t; rd = d; func = 6'h20; RegDst = 1; RegWrite = 1; ALUOp = 2'b10;
    endtask

    logic [5:0] ops [8] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h02, 6'h04};

    initial begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        // First reset cycle: DUT outputs are not yet defined, so stall is not compared.
        cycle("rst0", 1'b0);
        cycle("rst1", 1'b1);
        rst = 0;

        // Every register reads zero after reset.
        for (int i = 1; i < 32; i++) begin
            idle_inputs(); rs = i[4:0];
            cycle("rd_reset", 1'b1);
        end

        // Write r5 with bypass in the same cycle, then a plain read.
        idle_inputs(); wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; rs = 5;
        cycle("bypass", 1'b1);
        check("bypass.const", rs_data_o, 32'hDEADBEEF);
        idle_inputs(); rs = 5; rt = 5;
        cycle("readback", 1'b1);
        check("readback.const", rs_data_o, 32'hDEADBEEF);
        idle_inputs(); wb_we = 1; wb_addr = 0; wb_data = 32'h12345678; rs = 0;
        cycle("r0_write", 1'b1);
        idle_inputs(); rs = 0;
        cycle("r0_read", 1'b1);
        check("r0_read.const", rs_data_o, 32'h0);

        // Immediate extension.
        idle_inputs(); opcode = 6'h23; immediate = 16'h8004;
        cycle("imm_lw", 1'b1);
        check("imm_lw.const", imm_o, 32'hFFFF8004);
        idle_inputs(); opcode = 6'h0D; immediate = 16'h8004;
        cycle("imm_ori", 1'b1);
        check("imm_ori.const", imm_o, 32'h00008004);

        // Load-use: one stall cycle, one bubble, then the add proceeds.
        drive_lw(7);
        cycle("lu_lw", 1'b1);
        drive_add(7, 3, 8);
        cycle("lu_stall", 1'b1);
        check("lu_stall.const", {31'h0, last_stall}, 32'h1);
        check("lu_bubble.regwrite", {31'h0, RegWrite_o}, 32'h0);
        check("lu_bubble.memread", {31'h0, MemRead_o}, 32'h0);
        cycle("lu_go", 1'b1);
        check("lu_go.stall", {31'h0, stall}, 32'h0);
        check("lu_go.dest", {27'h0, dest_o}, 32'd8);
        check("lu_go.regwrite", {31'h0, RegWrite_o}, 32'h1);

        // rt used as immediate-path destination is not a hazard.
        drive_lw(7);
        cycle("neg_lw", 1'b1);
        idle_inputs(); opcode = 6'h08; rs = 3; rt = 7; ALUSrc = 1; RegWrite = 1; immediate = 16'h0001;
        cycle("neg_addi", 1'b1);
        check("neg_addi.const", {31'h0, last_stall}, 32'h0);

        // Flush beats load-use.
        drive_lw(7);
        cycle("fl_lw", 1'b1);
        drive_add(7, 7, 9); flush = 1;
        cycle("fl_add", 1'b1);
        check("fl_add.const", {31'h0, last_stall}, 32'h0);

        // Reset while a stall is pending clears it.
        drive_lw(4);
        cycle("rs_lw", 1'b1);
        drive_add(4, 1, 6); rst = 1;
        cycle("rs_mid", 1'b1);
        rst = 0;
        cycle("rs_after", 1'b1);
        check("rs_after.const", {31'h0, stall}, 32'h0);

        // Random traffic; stalled instructions are held as ID/RR would hold them.
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) begin
                opcode = ops[$urandom_range(0, 7)];
                rs = 5'($urandom_range(0, 7));
                rt = 5'($urandom_range(0, 7));
                rd = 5'($urandom_range(0, 7));
                func = 6'($urandom);
                address = 26'($urandom);
                immediate = 16'($urandom);
                {RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, Jump} = 6'($urandom);
                MemRead = ($urandom_range(0, 2) == 0);
                ALUOp = 2'($urandom);
            end
            flush = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 99) == 0);
            wb_we = $urandom_range(0, 1) == 1;
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            cycle("rand", 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
